// File: rtl/simple_cpu_pkg.sv
// simple_cpu_pkg: definitions shared across the simple_cpu data-memory slice.
//   DMEM_AW / DMEM_DEPTH : address width and number of bytes of data memory
//   dmem_state_t         : access FSM encoding used by simple_dmem
//   sat_inc16            : saturating +1 used by the access statistics counters
package simple_cpu_pkg;

  localparam int DMEM_AW    = 8;
  localparam int DMEM_DEPTH = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESP    = 2'd2,
    RELEASE = 2'd3
  } dmem_state_t;

  // Holds at all-ones instead of wrapping to zero.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/simple_dmem_array.sv
// simple_dmem_array: 256x8 single-port byte storage behind simple_dmem.
//   clk   : rising-edge clock
//   rst   : synchronous active-high; clears every byte and the read register
//   we    : write enable, mem[addr] <= wdata at the clock edge
//   re    : read enable, rdata <= mem[addr] at the clock edge
//   addr  : byte address shared by read and write
//   wdata : write data
//   rdata : registered read data, holds its value while re is low
module simple_dmem_array
  import simple_cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic               re,
  input  logic [DMEM_AW-1:0] addr,
  input  logic [7:0]         wdata,
  output logic [7:0]         rdata
);

  logic [7:0] mem [DMEM_DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DMEM_DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
      rdata <= 8'h00;
    end else begin
      if (we) begin
        mem[addr] <= wdata;
      end
      if (re) begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/simple_dmem.sv
// simple_dmem: 256x8 data memory answering the simple_cpu load/store interface.
// Optional feature macro: DMEM_WPROT_EN (drop stores below PROT_LIMIT).
//
// Parameters
//   WAIT_CYCLES : wait states between acceptance and mem_ready (0..15)
//   PROT_LIMIT  : stores to addresses below this are dropped (DMEM_WPROT_EN only)
// Ports
//   clk, rst    : rising-edge clock, synchronous active-high reset
//   mem_req     : access request, held by the CPU until it samples mem_ready
//   mem_we      : 1 = store, 0 = load
//   mem_addr    : byte address
//   mem_wdata   : store data
//   mem_rdata   : load data, valid with mem_ready and held until the next load
//   mem_ready   : one-cycle completion pulse
//   busy        : FSM is not IDLE
//   rd_count    : completed loads, saturating
//   wr_count    : completed stores (dropped ones included), saturating
//   wprot_err   : sticky flag, a protected store was dropped
//
// Handshake: a request is accepted on the edge where mem_req is high in IDLE;
// address, direction and data are latched there and later input changes are
// ignored. mem_ready pulses for exactly one cycle, WAIT_CYCLES+1 cycles after
// acceptance. The CPU must then drop mem_req for at least one cycle (RELEASE)
// before the next request is taken.
module simple_dmem
  import simple_cpu_pkg::*;
#(
  parameter int         WAIT_CYCLES = 2,
  parameter logic [7:0] PROT_LIMIT  = 8'h10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [7:0]  mem_addr,
  input  logic [7:0]  mem_wdata,
  output logic [7:0]  mem_rdata,
  output logic        mem_ready,
  output logic        busy,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count,
  output logic        wprot_err
);

  dmem_state_t state;
  logic [3:0]  wait_cnt;
  logic        lat_we;
  logic [7:0]  lat_addr;
  logic [7:0]  lat_wdata;
  logic        blocked;
  logic        arr_we;
  logic        arr_re;

`ifdef DMEM_WPROT_EN
  assign blocked = (lat_addr < PROT_LIMIT);
`else
  logic prot_unused;
  assign blocked     = 1'b0;
  assign prot_unused = ^PROT_LIMIT;
`endif

  // The array acts on the RESP edge, so its registered read lands in the
  // same cycle that mem_ready is high.
  assign arr_we = (state == RESP) && lat_we && !blocked;
  assign arr_re = (state == RESP) && !lat_we;
  assign busy   = (state != IDLE);

  simple_dmem_array u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (arr_we),
    .re    (arr_re),
    .addr  (lat_addr),
    .wdata (lat_wdata),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      lat_we    <= 1'b0;
      lat_addr  <= 8'h00;
      lat_wdata <= 8'h00;
      mem_ready <= 1'b0;
      rd_count  <= 16'h0000;
      wr_count  <= 16'h0000;
    end else begin
      mem_ready <= 1'b0;
      unique case (state)
        IDLE: begin
          if (mem_req) begin
            lat_we    <= mem_we;
            lat_addr  <= mem_addr;
            lat_wdata <= mem_wdata;
            wait_cnt  <= 4'(WAIT_CYCLES);
            state     <= (WAIT_CYCLES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          // Leave once the count has been worn down to 1; this places
          // mem_ready WAIT_CYCLES+1 cycles after acceptance.
          if (wait_cnt == 4'd1) begin
            state <= RESP;
          end
          wait_cnt <= wait_cnt - 4'd1;
        end
        RESP: begin
          mem_ready <= 1'b1;
          if (lat_we) begin
            wr_count <= sat_inc16(wr_count);
          end else begin
            rd_count <= sat_inc16(rd_count);
          end
          state <= RELEASE;
        end
        RELEASE: begin
          // The CPU still holds mem_req in the mem_ready cycle; wait for it
          // to drop so that cycle is not taken as a fresh request.
          if (!mem_req) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DMEM_WPROT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wprot_err <= 1'b0;
    end else if ((state == RESP) && lat_we && blocked) begin
      wprot_err <= 1'b1;
    end
  end
`else
  assign wprot_err = 1'b0;
`endif

endmodule

// File: tb/tb_simple_dmem.sv
module tb_simple_dmem;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // index 0: WAIT_CYCLES=2 instance, index 1: WAIT_CYCLES=0 instance
  logic [1:0]  req;
  logic [1:0]  we;
  logic [7:0]  addr  [2];
  logic [7:0]  wdata [2];
  logic [7:0]  rdata [2];
  logic [1:0]  ready;
  logic [1:0]  busy;
  logic [15:0] rdc [2];
  logic [15:0] wrc [2];
  logic [1:0]  werr;

  simple_dmem #(.WAIT_CYCLES(2)) dut_w2 (
    .clk(clk), .rst(rst), .mem_req(req[0]), .mem_we(we[0]), .mem_addr(addr[0]),
    .mem_wdata(wdata[0]), .mem_rdata(rdata[0]), .mem_ready(ready[0]), .busy(busy[0]),
    .rd_count(rdc[0]), .wr_count(wrc[0]), .wprot_err(werr[0])
  );

  simple_dmem #(.WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .rst(rst), .mem_req(req[1]), .mem_we(we[1]), .mem_addr(addr[1]),
    .mem_wdata(wdata[1]), .mem_rdata(rdata[1]), .mem_ready(ready[1]), .busy(busy[1]),
    .rd_count(rdc[1]), .wr_count(wrc[1]), .wprot_err(werr[1])
  );

  // ---------------- reference model / scoreboard ----------------
  logic [7:0]  model_mem [2][256];
  logic [15:0] exp_rd [2];
  logic [15:0] exp_wr [2];
  logic        exp_err [2];
  logic [7:0]  last_rd [2];
  logic [7:0]  exp_q [$];
  int n_checks = 0;
  int n_pass   = 0;

  function automatic int wait_of(input int inst);
    return (inst == 0) ? 2 : 0;
  endfunction

  function automatic logic [15:0] sat16(input logic [15:0] v);
    if (v == 16'hFFFF) return v;
    return v + 16'd1;
  endfunction

  function automatic logic is_prot(input logic w, input logic [7:0] a);
`ifdef DMEM_WPROT_EN
    return w && (a < 8'h10);
`else
    return 1'b0 && w && (a < 8'h10);
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 256; j++) model_mem[i][j] = 8'h00;
      exp_rd[i]  = 16'h0;
      exp_wr[i]  = 16'h0;
      exp_err[i] = 1'b0;
      last_rd[i] = 8'h00;
    end
    exp_q.delete();
  endtask

  // ---------------- driver ----------------
  // One full access: request, wait for mem_ready, optionally hold mem_req for
  // extra cycles, then drop it and let the FSM return to IDLE.
  task automatic do_access(input int inst, input logic w, input logic [7:0] a,
                           input logic [7:0] d, input int hold,
                           output int lat, output logic [7:0] rd_o,
                           output logic busy_acc, output logic busy_end,
                           output logic extra_ready);
    lat = 0; rd_o = 8'h00; busy_acc = 1'b0; busy_end = 1'b1; extra_ready = 1'b0;
    @(negedge clk);
    req[inst] = 1'b1; we[inst] = w; addr[inst] = a; wdata[inst] = d;
    if (!w) begin
      last_rd[inst] = model_mem[inst][a];
      exp_rd[inst]  = sat16(exp_rd[inst]);
    end else begin
      if (is_prot(w, a)) exp_err[inst] = 1'b1;
      else model_mem[inst][a] = d;
      exp_wr[inst] = sat16(exp_wr[inst]);
    end
    exp_q.push_back(last_rd[inst]);   // stores leave mem_rdata unchanged
    @(posedge clk); #1;
    busy_acc = busy[inst];
    // post-acceptance input changes must be ignored
    we[inst] = ~w; addr[inst] = 8'($urandom); wdata[inst] = 8'($urandom);
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (ready[inst]) break;
    end
    rd_o = rdata[inst];
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      if (ready[inst]) extra_ready = 1'b1;
    end
    @(negedge clk);
    req[inst] = 1'b0;
    @(posedge clk); #1;
    if (ready[inst]) extra_ready = 1'b1;
    busy_end = busy[inst];
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    req = 2'b00; we = 2'b00;
    addr[0] = 8'h00; addr[1] = 8'h00; wdata[0] = 8'h00; wdata[1] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (ready[i] !== 1'b0) $display("FAIL reset_ready[%0d]: got %b expected 0", i, ready[i]); else n_pass++;
      n_checks++; if (busy[i] !== 1'b0) $display("FAIL reset_busy[%0d]: got %b expected 0", i, busy[i]); else n_pass++;
      n_checks++; if (rdata[i] !== 8'h00) $display("FAIL reset_rdata[%0d]: got %h expected 00", i, rdata[i]); else n_pass++;
      n_checks++; if (rdc[i] !== 16'h0) $display("FAIL reset_rd_count[%0d]: got %h expected 0000", i, rdc[i]); else n_pass++;
      n_checks++; if (wrc[i] !== 16'h0) $display("FAIL reset_wr_count[%0d]: got %h expected 0000", i, wrc[i]); else n_pass++;
      n_checks++; if (werr[i] !== 1'b0) $display("FAIL reset_wprot_err[%0d]: got %b expected 0", i, werr[i]); else n_pass++;
    end
  endtask

  task automatic test_load_basic();
    int lat; logic [7:0] rd, e; logic ba, be, xr;
    do_access(0, 1'b0, 8'h20, 8'h00, 0, lat, rd, ba, be, xr);
    e = exp_q.pop_front();
    n_checks++; if (lat != 3) $display("FAIL load_latency: got %0d expected 3", lat); else n_pass++;
    n_checks++; if (rd !== e) $display("FAIL load_rdata: got %h expected %h", rd, e); else n_pass++;
    n_checks++; if (rdc[0] !== 16'd1) $display("FAIL load_rd_count: got %h expected 0001", rdc[0]); else n_pass++;
    n_checks++; if (ba !== 1'b1) $display("FAIL load_busy_rise: got %b expected 1", ba); else n_pass++;
    n_checks++; if (be !== 1'b0) $display("FAIL load_busy_fall: got %b expected 0", be); else n_pass++;
  endtask

  task automatic test_store_load();
    int lat; logic [7:0] rd, e; logic ba, be, xr;
    do_access(0, 1'b1, 8'h42, 8'hA5, 0, lat, rd, ba, be, xr);
    e = exp_q.pop_front();
    n_checks++; if (lat != 3) $display("FAIL store_latency: got %0d expected 3", lat); else n_pass++;
    n_checks++; if (rd !== e) $display("FAIL store_rdata_kept: got %h expected %h", rd, e); else n_pass++;
    n_checks++; if (wrc[0] !== 16'd1) $display("FAIL store_wr_count: got %h expected 0001", wrc[0]); else n_pass++;
    do_access(0, 1'b0, 8'h42, 8'h00, 1, lat, rd, ba, be, xr);
    e = exp_q.pop_front();
    n_checks++; if (rd !== 8'hA5 || rd !== e) $display("FAIL store_load_rdata: got %h expected %h", rd, e); else n_pass++;
    n_checks++; if (xr !== 1'b0) $display("FAIL held_req_second_ready: got %b expected 0", xr); else n_pass++;
    repeat (4) @(posedge clk);
    #1;
    n_checks++; if (rdc[0] !== exp_rd[0]) $display("FAIL held_req_rd_count: got %h expected %h", rdc[0], exp_rd[0]); else n_pass++;
    n_checks++; if (busy[0] !== 1'b0) $display("FAIL held_req_idle: got %b expected 0", busy[0]); else n_pass++;
  endtask

  task automatic test_zero_wait();
    int lat; logic [7:0] rd, e; logic ba, be, xr;
    do_access(1, 1'b1, 8'hFF, 8'h3C, 0, lat, rd, ba, be, xr);
    void'(exp_q.pop_front());
    n_checks++; if (lat != 1) $display("FAIL w0_store_latency: got %0d expected 1", lat); else n_pass++;
    do_access(1, 1'b0, 8'hFF, 8'h00, 0, lat, rd, ba, be, xr);
    e = exp_q.pop_front();
    n_checks++; if (lat != 1) $display("FAIL w0_load_latency: got %0d expected 1", lat); else n_pass++;
    n_checks++; if (rd !== 8'h3C || rd !== e) $display("FAIL w0_load_rdata: got %h expected %h", rd, e); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int lat; logic [7:0] rd, e; logic ba, be, xr; logic seen;
    seen = 1'b0;
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 8'h30; wdata[0] = 8'h77;
    @(posedge clk);          // accepted
    @(posedge clk);          // in WAIT
    @(negedge clk);
    rst = 1'b1; req[0] = 1'b0;
    @(posedge clk); #1;
    if (ready[0]) seen = 1'b1;
    @(negedge clk); rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (ready[0]) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) $display("FAIL rst_mid_ready: got %b expected 0", seen); else n_pass++;
    n_checks++; if (wrc[0] !== 16'h0) $display("FAIL rst_mid_wr_count: got %h expected 0000", wrc[0]); else n_pass++;
    do_access(0, 1'b0, 8'h30, 8'h00, 0, lat, rd, ba, be, xr);
    e = exp_q.pop_front();
    n_checks++; if (rd !== 8'h00 || rd !== e) $display("FAIL rst_mid_rdata: got %h expected %h", rd, e); else n_pass++;
  endtask

  task automatic test_wprot();
    int lat; logic [7:0] rd, e; logic ba, be, xr;
    do_access(0, 1'b1, 8'h05, 8'h11, 0, lat, rd, ba, be, xr);
    void'(exp_q.pop_front());
    n_checks++; if (lat != 3) $display("FAIL wprot_latency: got %0d expected 3", lat); else n_pass++;
    n_checks++; if (werr[0] !== exp_err[0]) $display("FAIL wprot_err: got %b expected %b", werr[0], exp_err[0]); else n_pass++;
    n_checks++; if (wrc[0] !== exp_wr[0]) $display("FAIL wprot_wr_count: got %h expected %h", wrc[0], exp_wr[0]); else n_pass++;
    do_access(0, 1'b0, 8'h05, 8'h00, 0, lat, rd, ba, be, xr);
    e = exp_q.pop_front();
    n_checks++; if (rd !== e) $display("FAIL wprot_load_rdata: got %h expected %h", rd, e); else n_pass++;
    n_checks++; if (werr[0] !== exp_err[0]) $display("FAIL wprot_err_sticky: got %b expected %b", werr[0], exp_err[0]); else n_pass++;
  endtask

  task automatic test_random();
    int lat; logic [7:0] rd, e; logic ba, be, xr;
    int inst; logic w; logic [7:0] a, d;
    for (int n = 0; n < 16; n++) begin
      inst = $urandom_range(0, 1);
      w    = 1'($urandom_range(0, 1));
      a    = 8'($urandom_range(8'h18, 8'h1F));   // small window so loads hit stored bytes
      d    = 8'($urandom_range(0, 255));
      do_access(inst, w, a, d, 0, lat, rd, ba, be, xr);
      e = exp_q.pop_front();
      n_checks++; if (lat != wait_of(inst) + 1) $display("FAIL rand_latency[%0d]: got %0d expected %0d", n, lat, wait_of(inst) + 1); else n_pass++;
      n_checks++; if (rd !== e) $display("FAIL rand_rdata[%0d]: got %h expected %h", n, rd, e); else n_pass++;
    end
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (rdc[i] !== exp_rd[i]) $display("FAIL rand_rd_count[%0d]: got %h expected %h", i, rdc[i], exp_rd[i]); else n_pass++;
      n_checks++; if (wrc[i] !== exp_wr[i]) $display("FAIL rand_wr_count[%0d]: got %h expected %h", i, wrc[i], exp_wr[i]); else n_pass++;
    end
  endtask

  task automatic test_saturation();
    int lat; logic [7:0] rd; logic ba, be, xr;
    @(negedge clk);
    force dut_w2.rd_count = 16'hFFFC;
    @(posedge clk);
    @(negedge clk);
    release dut_w2.rd_count;
    exp_rd[0] = 16'hFFFC;
    for (int i = 0; i < 2; i++) begin
      do_access(0, 1'b0, 8'h42, 8'h00, 0, lat, rd, ba, be, xr);
      void'(exp_q.pop_front());
    end
    n_checks++; if (rdc[0] !== 16'hFFFE) $display("FAIL sat_preload: got %h expected fffe", rdc[0]); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      do_access(0, 1'b0, 8'h42, 8'h00, 0, lat, rd, ba, be, xr);
      void'(exp_q.pop_front());
    end
    n_checks++; if (rdc[0] !== 16'hFFFF || exp_rd[0] !== 16'hFFFF) $display("FAIL sat_hold: got %h expected ffff", rdc[0]); else n_pass++;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_load_basic();
    test_store_load();
    test_zero_wait();
    test_reset_mid();
    test_wprot();
    test_random();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
